// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type, timing defaults and width helper for the button conditioner
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btnState_t;

  localparam int unsigned DEF_NUM_BTN       = 5;
  localparam int unsigned DEF_DEB_CYCLES    = 100000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;
  localparam bit          DEF_ACTIVE_HIGH   = 1'b1;

  // Bits needed by a counter that runs 0..n-1, never less than one bit
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button channel: synchroniser, debounce and auto-repeat FSM
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit          ACTIVE_HIGH   = DEF_ACTIVE_HIGH
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  input  logic repeatEn,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease
);

  localparam int unsigned DEB_W   = cntWidth(DEB_CYCLES);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cntWidth(REP_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic             rawPressed;
  logic             syncMeta;
  logic             btnSync;
  logic [DEB_W-1:0] debCnt;
  logic             mismatch;
  logic             accept;
  logic             accRise;
  logic             accFall;
  btnState_t        state;
  btnState_t        stateNext;
  logic [REP_W-1:0] repCnt;
  logic [REP_W-1:0] repCntNext;
  logic             repeatFire;

  assign rawPressed = ACTIVE_HIGH ? btnRaw : ~btnRaw;

  // Two-flop synchroniser; reset loads the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta <= 1'b0;
      btnSync  <= 1'b0;
    end else begin
      syncMeta <= rawPressed;
      btnSync  <= syncMeta;
    end
  end

  assign mismatch = (btnSync != btnLevel);
  assign accept   = mismatch && (debCnt == DEB_LAST);
  assign accRise  = accept && btnSync;
  assign accFall  = accept && !btnSync;

  // Debounce: count consecutive mismatching edges; any matching edge restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      debCnt   <= '0;
      btnLevel <= 1'b0;
    end else if (accept) begin
      debCnt   <= '0;
      btnLevel <= btnSync;
    end else if (mismatch) begin
      debCnt   <= debCnt + 1'b1;
    end else begin
      debCnt   <= '0;
    end
  end

  // Repeat FSM state and repeat interval counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RELEASED;
      repCnt <= '0;
    end else begin
      state  <= stateNext;
      repCnt <= repCntNext;
    end
  end

  // Next state and repeat timing; an accepted release outranks a repeat due in the same cycle
  always_comb begin
    stateNext  = state;
    repCntNext = repCnt;
    repeatFire = 1'b0;
    case (state)
      RELEASED: begin
        repCntNext = '0;
        if (accRise) begin
          stateNext = HELD;
        end
      end
      HELD, REPEATING: begin
        if (accFall) begin
          stateNext  = RELEASED;
          repCntNext = '0;
        end else if (!repeatEn) begin
          stateNext  = HELD;
          repCntNext = '0;
        end else if (repCnt == ((state == HELD) ? DELAY_LAST : PERIOD_LAST)) begin
          repeatFire = 1'b1;
          repCntNext = '0;
          stateNext  = REPEATING;
        end else begin
          repCntNext = repCnt + 1'b1;
        end
      end
      default: begin
        stateNext  = RELEASED;
        repCntNext = '0;
      end
    endcase
  end

  // Pulses are registered beside btnLevel so a press lines up with the level rising
  always_ff @(posedge clk) begin
    if (rst) begin
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
    end else begin
      btnPress   <= accRise | repeatFire;
      btnRelease <= accFall;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - NUM_BTN independent button channels plus a registered any-press flag
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN       = DEF_NUM_BTN,
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit          ACTIVE_HIGH   = DEF_ACTIVE_HIGH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
    btn_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .ACTIVE_HIGH  (ACTIVE_HIGH)
    ) uChan (
      .clk       (clk),
      .rst       (rst),
      .btnRaw    (btn_in[i]),
      .repeatEn  (repeat_en[i]),
      .btnLevel  (btn_level[i]),
      .btnPress  (btn_press[i]),
      .btnRelease(btn_release[i])
    );
  end

  // any_press trails btn_press by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |btn_press;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  int nCmp = 0;
  int nBad = 0;

  // Reference model state
  logic [NB-1:0]  mS1, mS2, mLvl, mPress, mRel, mHeld, mRep;
  logic           mAny;
  logic [DEB-1:0] mWin [NB];
  int             mAnchor [NB];
  int             cyc = 0;

  typedef struct {
    logic [NB-1:0] mask;
    bit            rep;
    int            hold;
    int            pressEdge;
    int            pulses;
    int            relEdge;
    int            anyEdge;
  } vec_t;

  vec_t vecs [6];

  btn_conditioner #(
    .NUM_BTN      (NB),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER),
    .ACTIVE_HIGH  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Level accepted once the last DEB synchronised samples all disagree with it;
  // repeats are timestamped from the press, the last repeat, or the last disabled cycle.
  task automatic modelStep();
    logic samp, rise, fall, fire;
    if (rst) begin
      mS1 = '0; mS2 = '0; mLvl = '0; mPress = '0; mRel = '0;
      mHeld = '0; mRep = '0; mAny = 1'b0;
      for (int c = 0; c < NB; c++) begin
        mWin[c] = '0;
        mAnchor[c] = 0;
      end
    end else begin
      mAny = |mPress;
      for (int c = 0; c < NB; c++) begin
        samp = mS2[c];
        mS2[c] = mS1[c];
        mS1[c] = btn_in[c];
        mWin[c] = {mWin[c][DEB-2:0], samp};
        rise = 1'b0; fall = 1'b0; fire = 1'b0;
        if (mWin[c] == {DEB{~mLvl[c]}}) begin
          mLvl[c] = ~mLvl[c];
          rise = mLvl[c];
          fall = ~mLvl[c];
        end
        if (fall) begin
          mHeld[c] = 1'b0;
        end else if (rise) begin
          mHeld[c] = 1'b1;
          mRep[c] = 1'b0;
          mAnchor[c] = cyc;
        end else if (mHeld[c]) begin
          if (!repeat_en[c]) begin
            mAnchor[c] = cyc;
            mRep[c] = 1'b0;
          end else if (cyc - mAnchor[c] == (mRep[c] ? PER : DLY)) begin
            fire = 1'b1;
            mAnchor[c] = cyc;
            mRep[c] = 1'b1;
          end
        end
        mPress[c] = rise | fire;
        mRel[c] = fall;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    check("model_level", 32'(btn_level), 32'(mLvl));
    check("model_press", 32'(btn_press), 32'(mPress));
    check("model_release", 32'(btn_release), 32'(mRel));
    check("model_any", 32'(any_press), 32'(mAny));
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitPress(input int ch, input int budget, output int edges);
    edges = -1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk); #1;
      if (btn_press[ch]) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int  pE [NB];
    int  rE [NB];
    int  pN [NB];
    int  anyE;
    int  t;
    bit  quiet;
    anyE = -1; t = 0; quiet = 1'b1;
    for (int c = 0; c < NB; c++) begin
      pE[c] = -1; rE[c] = -1; pN[c] = 0;
    end
    btn_in = v.mask;
    repeat_en = v.rep ? v.mask : '0;
    for (int e = 1; e <= v.hold + 12; e++) begin
      if (e == v.hold + 1) btn_in = '0;
      @(posedge clk); #1;
      t++;
      for (int c = 0; c < NB; c++) begin
        if (btn_press[c]) begin
          pN[c]++;
          if (pE[c] < 0) pE[c] = t;
        end
        if (btn_release[c] && rE[c] < 0) rE[c] = t - v.hold;
        if (!v.mask[c] && (btn_level[c] || btn_press[c] || btn_release[c])) quiet = 1'b0;
      end
      if (any_press && anyE < 0) anyE = t;
    end
    repeat_en = '0;
    for (int c = 0; c < NB; c++) begin
      if (v.mask[c]) begin
        check($sformatf("vec%0d_ch%0d_press_edge", idx, c), pE[c], v.pressEdge);
        check($sformatf("vec%0d_ch%0d_pulses", idx, c), pN[c], v.pulses);
        check($sformatf("vec%0d_ch%0d_release_edge", idx, c), rE[c], v.relEdge);
      end
    end
    check($sformatf("vec%0d_other_quiet", idx), 32'(quiet), 32'd1);
    check($sformatf("vec%0d_any_edge", idx), anyE, v.anyEdge);
    idle(8);
  endtask

  initial begin
    int edges;
    int bounced;
    int rstLeft;
    logic [7:0] bounce;

    vecs[0] = '{mask: 5'b00001, rep: 1'b0, hold: 10, pressEdge: 6,  pulses: 1, relEdge: 6,  anyEdge: 7};
    vecs[1] = '{mask: 5'b01010, rep: 1'b0, hold: 10, pressEdge: 6,  pulses: 1, relEdge: 6,  anyEdge: 7};
    vecs[2] = '{mask: 5'b00100, rep: 1'b1, hold: 60, pressEdge: 6,  pulses: 6, relEdge: 6,  anyEdge: 7};
    vecs[3] = '{mask: 5'b11111, rep: 1'b1, hold: 30, pressEdge: 6,  pulses: 3, relEdge: 6,  anyEdge: 7};
    vecs[4] = '{mask: 5'b10000, rep: 1'b0, hold: 3,  pressEdge: -1, pulses: 0, relEdge: -1, anyEdge: -1};
    vecs[5] = '{mask: 5'b10000, rep: 1'b0, hold: 4,  pressEdge: 6,  pulses: 1, relEdge: 6,  anyEdge: 7};

    // Reset state
    idle(3);
    check("reset_outputs", 32'({btn_level, btn_press, btn_release, any_press}), 32'd0);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 6; i++) runVec(i, vecs[i]);

    // Bounce 1-0-1-0 at 2-cycle intervals, then stable press
    bounce = 8'b00110011;
    bounced = 0;
    for (int i = 0; i < 8; i++) begin
      btn_in[0] = bounce[i];
      @(posedge clk); #1;
      if (btn_press[0]) bounced++;
    end
    btn_in[0] = 1'b1;
    waitPress(0, 20, edges);
    check("bounce_quiet", bounced, 0);
    check("bounce_press_edge", edges, 6);
    bounced = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (btn_press[0]) bounced++;
    end
    check("bounce_single_press", bounced, 0);
    btn_in[0] = 1'b0;
    idle(12);

    // repeat_en dropped 15 cycles after the press, re-raised 5 cycles later
    btn_in[1] = 1'b1;
    repeat_en[1] = 1'b1;
    waitPress(1, 20, edges);
    check("rep_drop_press_edge", edges, 6);
    idle(15);
    repeat_en[1] = 1'b0;
    idle(5);
    repeat_en[1] = 1'b1;
    waitPress(1, 40, edges);
    check("rep_reraise_delay", edges, DLY);
    btn_in[1] = 1'b0;
    repeat_en[1] = 1'b0;
    idle(12);

    // Reset while channel 2 is auto-repeating, button kept held
    btn_in[2] = 1'b1;
    repeat_en[2] = 1'b1;
    waitPress(2, 20, edges);
    check("rst_rep_press_edge", edges, 6);
    idle(30);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold_outputs_%0d", i), 32'({btn_level, btn_press, btn_release, any_press}), 32'd0);
    end
    rst = 1'b0;
    waitPress(2, 20, edges);
    check("rst_release_press_edge", edges, 6);
    btn_in[2] = 1'b0;
    repeat_en[2] = 1'b0;
    idle(12);

    // Randomised traffic, checked against the model every cycle
    rstLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rstLeft > 0) begin
        rstLeft--;
        if (rstLeft == 0) rst = 1'b0;
      end else if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        rstLeft = 2;
      end
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 6 + 12 * c) == 0) btn_in[c] = ~btn_in[c];
        if ($urandom_range(0, 59) == 0) repeat_en[c] = ~repeat_en[c];
      end
    end
    rst = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
